// File: rtl/pipe_stall_regs_if.sv
// Pipeline register bus for pipe_stall_regs: the stall request and the next-stage
// inputs go in, and the PC, F/D and D/E register contents and the stall statistics
// come out. The master drives the inputs and the slave (the register block) drives
// the outputs.
interface pipe_stall_regs_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic [31:0]      npc;
    logic [31:0]      F_instr;
    logic [31:0]      D_rs_data;
    logic [31:0]      D_rt_data;
    logic [31:0]      D_ext;

    logic [31:0]      F_pc;
    logic [31:0]      D_instr;
    logic [31:0]      D_pc;
    logic [31:0]      E_instr;
    logic [31:0]      E_pc;
    logic [31:0]      E_rs_data;
    logic [31:0]      E_rt_data;
    logic [31:0]      E_ext;
    logic             E_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_err;

    modport master (
        output stall, npc, F_instr, D_rs_data, D_rt_data, D_ext,
        input  F_pc, D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext,
        input  E_bubble, stall_cnt, stall_err
    );

    modport slave (
        input  stall, npc, F_instr, D_rs_data, D_rt_data, D_ext,
        output F_pc, D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext,
        output E_bubble, stall_cnt, stall_err
    );
endinterface

// File: rtl/pipe_stall_regs.sv
// PC, F/D and D/E pipeline registers with stall handling. A stall request freezes
// the PC and F/D and puts a nop bubble into D/E. The block also counts stalled
// cycles (saturating) and sets a sticky flag when a stall run is longer than
// MAX_STALL_RUN.
module pipe_stall_regs #(
    parameter logic [31:0] PC_RESET      = 32'h0000_3000,
    parameter int unsigned MAX_STALL_RUN = 2,
    parameter int unsigned CNT_W         = 32
) (
    input logic              clk,
    input logic              reset,
    pipe_stall_regs_if.slave bus
);
    // The run counter must be able to hold MAX_STALL_RUN + 1.
    localparam int unsigned RUN_W = $clog2(MAX_STALL_RUN + 2);
    localparam logic [RUN_W-1:0] RunLimit = RUN_W'(MAX_STALL_RUN);
    localparam logic [RUN_W-1:0] RunSat   = RUN_W'(MAX_STALL_RUN + 1);

    logic [31:0]      f_pc_q, f_pc_d;
    logic [31:0]      d_instr_q, d_instr_d;
    logic [31:0]      d_pc_q, d_pc_d;
    logic [31:0]      e_instr_q, e_instr_d;
    logic [31:0]      e_pc_q, e_pc_d;
    logic [31:0]      e_rs_data_q, e_rs_data_d;
    logic [31:0]      e_rt_data_q, e_rt_data_d;
    logic [31:0]      e_ext_q, e_ext_d;
    logic             e_bubble_q, e_bubble_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_err_q, stall_err_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Next-state for the pipeline registers: advance normally, or freeze and insert a bubble.
    always_comb begin
        f_pc_d      = f_pc_q;
        d_instr_d   = d_instr_q;
        d_pc_d      = d_pc_q;
        e_instr_d   = '0;
        e_pc_d      = d_pc_q;  // a bubble keeps the stalled PC so debug traces still show it
        e_rs_data_d = '0;
        e_rt_data_d = '0;
        e_ext_d     = '0;
        e_bubble_d  = 1'b1;
        if (!bus.stall) begin
            f_pc_d      = bus.npc;
            d_instr_d   = bus.F_instr;
            d_pc_d      = f_pc_q;
            e_instr_d   = d_instr_q;
            e_rs_data_d = bus.D_rs_data;
            e_rt_data_d = bus.D_rt_data;
            e_ext_d     = bus.D_ext;
            e_bubble_d  = 1'b0;
        end
    end

    // Next-state for the stall statistics, the run-length counter and the sticky error flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        run_d       = '0;
        if (bus.stall) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            run_d = (run_q == RunSat) ? run_q : run_q + RUN_W'(1);
            if (run_q == RunLimit) begin
                stall_err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q      <= PC_RESET;
            d_instr_q   <= '0;
            d_pc_q      <= '0;
            e_instr_q   <= '0;
            e_pc_q      <= '0;
            e_rs_data_q <= '0;
            e_rt_data_q <= '0;
            e_ext_q     <= '0;
            e_bubble_q  <= 1'b0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
            run_q       <= '0;
        end else begin
            f_pc_q      <= f_pc_d;
            d_instr_q   <= d_instr_d;
            d_pc_q      <= d_pc_d;
            e_instr_q   <= e_instr_d;
            e_pc_q      <= e_pc_d;
            e_rs_data_q <= e_rs_data_d;
            e_rt_data_q <= e_rt_data_d;
            e_ext_q     <= e_ext_d;
            e_bubble_q  <= e_bubble_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            run_q       <= run_d;
        end
    end

    // Register outputs onto the bus.
    always_comb begin
        bus.F_pc      = f_pc_q;
        bus.D_instr   = d_instr_q;
        bus.D_pc      = d_pc_q;
        bus.E_instr   = e_instr_q;
        bus.E_pc      = e_pc_q;
        bus.E_rs_data = e_rs_data_q;
        bus.E_rt_data = e_rt_data_q;
        bus.E_ext     = e_ext_q;
        bus.E_bubble  = e_bubble_q;
        bus.stall_cnt = stall_cnt_q;
        bus.stall_err = stall_err_q;
    end
endmodule
